pwm_multi_channel_gen: RTL and testbench
========================================

// Module: pwm_multi_channel_gen
// PURPOSE
//  Multi-channel PWM generator with per-channel duty cycles.
//  - A shared period counter drives CHANNELS registered PWM outputs.
//  - Duty of the channel picked by ui_sel is stepped up/down by debounced push-buttons.
//  - Duty changes are double-buffered and take effect only at a period boundary, so outputs never glitch.
//  - Sits between the top-level ui_*/uo_* pins and downstream loads (LEDs, motor drivers).
// PARAMETERS
//  CHANNELS   4   number of PWM outputs (1..8)
//  CNT_W      8   width of period counter and duty registers
//  PERIOD     10  counts per PWM period (2..2**CNT_W-1); duty range 0..PERIOD
//  STEP       1   duty increment/decrement per accepted press
//  DUTY_RST   5   reset duty of every channel (<=PERIOD)
//  DEB_CYCLES 4   consecutive synced-high cycles required to accept a press
// PORTS
//  clk              in  1                     system clock
//  rst              in  1                     asynchronous, active-high reset
//  ena              in  1                     block enable
//  ui_sel           in  $clog2(CHANNELS)      channel targeted by button presses
//  ui_increase_duty in  1                     raw async button: raise duty
//  ui_decrease_duty in  1                     raw async button: lower duty
//  uo_pwm_out       out CHANNELS              registered PWM outputs
//  uo_duty          out CNT_W                 shadow duty of channel ui_sel
//  uo_period_start  out 1                     1-cycle pulse when counter wraps to 0
// BEHAVIOUR
//  Reset (async, any time):
//    - cnt=0; shadow and active duty = DUTY_RST for all channels.
//    - uo_pwm_out=0, uo_period_start=0; debouncers cleared.
//  Buttons:
//    - 2-FF synchroniser, then debounce.
//    - A press is accepted once, as a 1-cycle pulse, after DEB_CYCLES consecutive high cycles.
//    - The input must go low before the next press can be accepted; holding never auto-repeats.
//  Duty update (shadow[ui_sel]):
//    - inc: min(shadow+STEP, PERIOD).
//    - dec: if shadow<STEP, 0; else shadow-STEP.
//    - inc and dec pulses in the same cycle: no change.
//    - ui_sel>=CHANNELS: press ignored.
//    - Arithmetic in CNT_W+1 bits, then saturated.
//  Latency:
//    - Button edge to uo_duty change is 2+DEB_CYCLES+1 cycles.
//    - Shadow copies to active at the cycle cnt wraps PERIOD-1->0.
//  Counter (edge-aligned): 0..PERIOD-1, increments when ena=1, wraps to 0.
//  Output: uo_pwm_out[i] <= (cnt < active[i]); registered, 1 cycle after cnt.
//    - duty=0: constantly low.
//    - duty=PERIOD: constantly high.
//  uo_period_start: registered, high for the cycle after the wrap.
//  ena=0:
//    - cnt holds; uo_pwm_out and uo_period_start forced 0 next cycle.
//    - Presses ignored and debouncers cleared; shadow/active duties retained.
//  ena re-asserted: resume from the held cnt.
// CONFIGURATION
//  PWM_CENTER_ALIGN_EN defined:
//    - Counter runs up 0..PERIOD, then down to 0 (period 2*PERIOD cycles).
//    - Output high while cnt < active[i], symmetric about the period centre.
//    - Shadow->active load and uo_period_start occur at cnt==0 on the turn from down to up.
//  Undefined: edge-aligned mode only, as above; no up/down direction state.
// STRUCTURE
//  pwm_pkg:
//    - Duty/counter typedefs sized by CNT_W.
//    - Saturating add/sub functions.
//    - Channel-select width function.
//  Sub-module pwm_button_debounce (synchroniser + stability counter + one-shot), instanced twice.
//  Top holds counter, shadow/active duty arrays, compare logic.
// TESTING (defaults)
//  1. rst=1 mid-run -> uo_pwm_out=0 at once, uo_duty=5; after release each channel is high 5 of 10 cycles.
//  2. sel=0, inc held 10 cycles -> one step only: uo_duty=6; ch0 high 6/10 from next period, ch1..3 stay 5/10.
//  3. sel=2: 6 inc presses -> duty 10, ch2 constantly high; 12 dec presses -> 0, constantly low, no underflow.
//  4. inc pulse 3 cycles (<DEB_CYCLES) -> no change; inc and dec held together -> no change.
//  5. Press accepted at cnt=3 -> current period keeps old duty; new duty from cycle after uo_period_start.
//  6. ena=0 at cnt=4 for 20 cycles -> outputs 0, cnt stays 4, presses ignored; ena=1 resumes at 4.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and helpers for the multi-channel PWM generator.
// Duty/counter types are sized by PWM_CNT_W; the top's CNT_W defaults to it.
package pwm_pkg;

    localparam int PWM_CNT_W = 8;

    typedef logic [PWM_CNT_W-1:0] duty_t;
    typedef logic [PWM_CNT_W:0]   duty_ext_t;

    // Width of a channel-select bus; never narrower than one bit.
    function automatic int sel_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    function automatic duty_t sat_add(input duty_t a, input duty_t step, input duty_t lim);
        duty_ext_t sum;
        sum = duty_ext_t'(a) + duty_ext_t'(step);
        return (sum > duty_ext_t'(lim)) ? lim : sum[PWM_CNT_W-1:0];
    endfunction

    function automatic duty_t sat_sub(input duty_t a, input duty_t step);
        duty_ext_t diff;
        diff = duty_ext_t'(a) - duty_ext_t'(step);
        // The extra top bit is the borrow: set means the result went below zero.
        return diff[PWM_CNT_W] ? '0 : diff[PWM_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/pwm_button_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter and one-shot press pulse.
// A press fires once after DEB_CYCLES synced-high cycles and re-arms only after release.
module pwm_button_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic btn_i,
    output logic press_o
);

    localparam int                DEB_W   = $clog2(DEB_CYCLES + 1);
    localparam logic [DEB_W-1:0]  DEB_MAX = DEB_W'(DEB_CYCLES);

    logic             sync1_q, sync2_q;
    logic [DEB_W-1:0] stable_q, stable_d;
    logic             press_q, press_d;

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        stable_d = stable_q;
        press_d  = 1'b0;
        if (clear_i || !sync2_q) begin
            stable_d = '0;
        end else if (stable_q != DEB_MAX) begin
            stable_d = stable_q + 1'b1;
            press_d  = (stable_q == DEB_MAX - 1'b1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= '0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= clear_i ? 1'b0 : btn_i;
            sync2_q  <= clear_i ? 1'b0 : sync1_q;
            stable_q <= stable_d;
            press_q  <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/pwm_multi_channel_gen.sv
// Multi-channel PWM generator: shared period counter, double-buffered per-channel duty.
// Define PWM_CENTER_ALIGN_EN for an up/down (centre-aligned) counter; default is edge-aligned.
module pwm_multi_channel_gen
    import pwm_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int CNT_W      = PWM_CNT_W,
    parameter int PERIOD     = 10,
    parameter int STEP       = 1,
    parameter int DUTY_RST   = 5,
    parameter int DEB_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ena,
    input  logic [sel_w(CHANNELS)-1:0] ui_sel,
    input  logic                       ui_increase_duty,
    input  logic                       ui_decrease_duty,
    output logic [CHANNELS-1:0]        uo_pwm_out,
    output logic [CNT_W-1:0]           uo_duty,
    output logic                       uo_period_start
);

    localparam duty_t PERIOD_D   = duty_t'(PERIOD);
    localparam duty_t LAST_D     = duty_t'(PERIOD - 1);
    localparam duty_t STEP_D     = duty_t'(STEP);
    localparam duty_t DUTY_RST_D = duty_t'(DUTY_RST);

    logic                inc_press, dec_press, sel_valid, period_wrap;
    duty_t               cnt_q, cnt_d;
    duty_t               shadow_q [CHANNELS];
    duty_t               shadow_d [CHANNELS];
    duty_t               active_q [CHANNELS];
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic                period_start_q;

    pwm_button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
        .clk     (clk),
        .rst     (rst),
        .clear_i (!ena),
        .btn_i   (ui_increase_duty),
        .press_o (inc_press)
    );

    pwm_button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dec (
        .clk     (clk),
        .rst     (rst),
        .clear_i (!ena),
        .btn_i   (ui_decrease_duty),
        .press_o (dec_press)
    );

    assign sel_valid = int'(ui_sel) < CHANNELS;

    // Simultaneous inc and dec presses cancel out.
    always_comb begin
        shadow_d = shadow_q;
        if (ena && sel_valid && (inc_press ^ dec_press)) begin
            shadow_d[ui_sel] = inc_press ? sat_add(shadow_q[ui_sel], STEP_D, PERIOD_D)
                                         : sat_sub(shadow_q[ui_sel], STEP_D);
        end
    end

`ifdef PWM_CENTER_ALIGN_EN
    localparam duty_t ONE_D = duty_t'(1);
    logic dir_down_q, dir_down_d;

    // Up 0..PERIOD, down to 0; the period boundary is the down->up turn at zero.
    always_comb begin
        cnt_d       = cnt_q;
        dir_down_d  = dir_down_q;
        period_wrap = 1'b0;
        if (ena) begin
            if (!dir_down_q) begin
                if (cnt_q == PERIOD_D) begin
                    dir_down_d = 1'b1;
                    cnt_d      = cnt_q - 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == ONE_D) begin
                    dir_down_d  = 1'b0;
                    period_wrap = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) dir_down_q <= 1'b0;
        else     dir_down_q <= dir_down_d;
    end
`else
    always_comb begin
        cnt_d       = cnt_q;
        period_wrap = 1'b0;
        if (ena) begin
            period_wrap = (cnt_q == LAST_D);
            cnt_d       = period_wrap ? '0 : cnt_q + 1'b1;
        end
    end
`endif

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            pwm_d[i] = ena && (cnt_q < active_q[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q          <= '0;
            pwm_q          <= '0;
            period_start_q <= 1'b0;
            // NOTE: the duty arrays are a handful of flops that must come up at DUTY_RST, so they are reset, not RAM.
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= DUTY_RST_D;
                active_q[i] <= DUTY_RST_D;
            end
        end else begin
            cnt_q          <= cnt_d;
            pwm_q          <= pwm_d;
            period_start_q <= period_wrap;
            shadow_q       <= shadow_d;
            if (period_wrap) active_q <= shadow_q;
        end
    end

    assign uo_pwm_out      = pwm_q;
    assign uo_period_start = period_start_q;
    assign uo_duty         = sel_valid ? shadow_q[ui_sel] : '0;

endmodule

// File: tb/tb_pwm_multi_channel_gen.sv
// Directed, table-driven bench for pwm_multi_channel_gen at default parameters.
module tb_pwm_multi_channel_gen;

    localparam int CH  = 4;
    localparam int PER = 10;

    logic          clk = 1'b0;
    logic          rst, ena, inc, dec;
    logic [1:0]    sel;
    logic [CH-1:0] pwm;
    logic [7:0]    duty;
    logic          ps;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pwm_multi_channel_gen dut (
        .clk              (clk),
        .rst              (rst),
        .ena              (ena),
        .ui_sel           (sel),
        .ui_increase_duty (inc),
        .ui_decrease_duty (dec),
        .uo_pwm_out       (pwm),
        .uo_duty          (duty),
        .uo_period_start  (ps)
    );

    typedef struct {
        logic [1:0] sel;
        logic       inc;
        logic       dec;
        int         len;
        int         exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void add(input logic [1:0] s, input logic i, input logic d, input int len, input int exp);
        vec_t v;
        v.sel = s; v.inc = i; v.dec = d; v.len = len; v.exp = exp;
        vecs.push_back(v);
    endfunction

    function automatic logic [PER-1:0] exp_pat(input int d);
        logic [PER-1:0] r;
        for (int k = 0; k < PER; k++) r[k] = (k < d);
        return r;
    endfunction

    task automatic wait_ps(input string tag);
        bit found = 0;
        for (int i = 0; i < 3 * PER && !found; i++) begin
            @(negedge clk);
            if (ps) found = 1;
        end
        check({tag, " period_start seen"}, 32'(found), 1);
    endtask

    // Entered on the negedge where period_start is high; ends on the next such negedge.
    task automatic run_period(input string tag, input bit press, input int d[CH]);
        logic [CH-1:0][PER-1:0] pat;
        int ps_early = 0;
        if (press) inc = 1'b1;
        for (int k = 0; k < PER; k++) begin
            @(negedge clk);
            if (press && k == 5) inc = 1'b0;
            for (int c = 0; c < CH; c++) pat[c][k] = pwm[c];
            if (k < PER - 1 && ps) ps_early++;
        end
        check({tag, " early period_start"}, ps_early, 0);
        check({tag, " period_start at wrap"}, 32'(ps), 1);
        for (int c = 0; c < CH; c++)
            check($sformatf("%s ch%0d pattern", tag, c), 32'(pat[c]), 32'(exp_pat(d[c])));
    endtask

    initial begin
        int bad;
        int n;
        int found_at;

        rst = 1'b1; ena = 1'b1; inc = 1'b0; dec = 1'b0; sel = 2'd0;

        add(2'd0, 1, 0, 10, 6);
        add(2'd2, 1, 0, 5, 6);  add(2'd2, 1, 0, 5, 7);  add(2'd2, 1, 0, 5, 8);
        add(2'd2, 1, 0, 5, 9);  add(2'd2, 1, 0, 5, 10); add(2'd2, 1, 0, 5, 10);
        add(2'd2, 0, 1, 5, 9);  add(2'd2, 0, 1, 5, 8);  add(2'd2, 0, 1, 5, 7);
        add(2'd2, 0, 1, 5, 6);  add(2'd2, 0, 1, 5, 5);  add(2'd2, 0, 1, 5, 4);
        add(2'd2, 0, 1, 5, 3);  add(2'd2, 0, 1, 5, 2);  add(2'd2, 0, 1, 5, 1);
        add(2'd2, 0, 1, 5, 0);  add(2'd2, 0, 1, 5, 0);  add(2'd2, 0, 1, 5, 0);
        add(2'd1, 1, 0, 3, 5);
        add(2'd1, 1, 1, 6, 5);
        add(2'd3, 0, 1, 4, 4);

        repeat (3) @(negedge clk);
        check("reset pwm", 32'(pwm), 0);
        check("reset period_start", 32'(ps), 0);
        check("reset duty", 32'(duty), 5);
        rst = 1'b0;

        wait_ps("init");
        run_period("init", 0, '{5, 5, 5, 5});

        foreach (vecs[v]) begin
            @(negedge clk);
            sel = vecs[v].sel; inc = vecs[v].inc; dec = vecs[v].dec;
            repeat (vecs[v].len) @(negedge clk);
            inc = 1'b0; dec = 1'b0;
            repeat (10) @(negedge clk);
            check($sformatf("vec%0d duty", v), 32'(duty), 32'(vecs[v].exp));
        end

        wait_ps("table");
        run_period("table", 0, '{6, 5, 0, 4});

        // Press lands mid-period: current period keeps the old duty, next one uses the new.
        sel = 2'd1;
        run_period("press mid", 1, '{6, 5, 0, 4});
        check("press mid duty", 32'(duty), 6);
        run_period("press next", 0, '{6, 6, 0, 4});

        // Disable at cnt=4 for 20 cycles with a press in the middle.
        repeat (4) @(negedge clk);
        ena = 1'b0; sel = 2'd3; bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 2)  inc = 1'b1;
            if (i == 12) inc = 1'b0;
            if (pwm != '0 || ps) bad++;
        end
        check("disabled outputs low", bad, 0);
        check("disabled press ignored", 32'(duty), 4);
        ena = 1'b1;
        found_at = 0;
        for (int i = 1; i <= 3 * PER && found_at == 0; i++) begin
            @(negedge clk);
            if (i == 1) check("resume pwm at cnt4", 32'(pwm), 32'b0011);
            if (ps) found_at = i;
        end
        check("resume cycles to wrap", found_at, 6);

        // Button edge to uo_duty change latency.
        sel = 2'd3; inc = 1'b1; n = 0;
        for (int i = 1; i <= 20 && n == 0; i++) begin
            @(negedge clk);
            if (i == 8) inc = 1'b0;
            if (duty != 8'd4) n = i;
        end
        inc = 1'b0;
        check("press latency", n, 7);
        check("latency new duty", 32'(duty), 5);
        repeat (6) @(negedge clk);

        // Asynchronous reset mid-period.
        wait_ps("pre reset");
        repeat (2) @(negedge clk);
        sel = 2'd0;
        #2 rst = 1'b1;
        #1;
        check("async reset pwm", 32'(pwm), 0);
        check("async reset period_start", 32'(ps), 0);
        check("async reset duty", 32'(duty), 5);
        @(negedge clk);
        rst = 1'b0;
        wait_ps("post reset");
        run_period("post reset", 0, '{5, 5, 5, 5});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
